// File: rtl/coin_change_dispenser_if.sv
// Job/coin/status bundle for coin_change_dispenser.
// The master side is the job source plus the coin mechanism; the slave side is the dispenser.
interface coin_change_dispenser_if;
  logic        load;
  logic [3:0]  five;
  logic [3:0]  ten;
  logic [3:0]  twenty;
  logic [3:0]  fifty;
  logic [3:0]  hundred;
  logic        abort;
  logic        coin_ack;
  logic [4:0]  coin_out;
  logic        coin_valid;
  logic        busy;
  logic        done;
  logic        fault;
  logic [11:0] value_left;
  logic [4:0]  hopper_empty;

  modport master (
    output load, five, ten, twenty, fifty, hundred, abort, coin_ack,
    input  coin_out, coin_valid, busy, done, fault, value_left, hopper_empty
  );

  modport slave (
    input  load, five, ten, twenty, fifty, hundred, abort, coin_ack,
    output coin_out, coin_valid, busy, done, fault, value_left, hopper_empty
  );
endinterface

// File: rtl/coin_change_dispenser.sv
// Coin-out sequencer: pays latched change counts one coin per valid/ack, largest first.
// Optional HOPPER_COUNT_EN adds per-denomination stock counters and a hopper-empty fault.
module coin_change_dispenser #(
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned HOPPER_INIT = 15
) (
  input logic                   clk,
  input logic                   reset,
  coin_change_dispenser_if.slave bus
);

  localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  if (GAP_CYCLES < 1 || ACK_TIMEOUT < 1 || HOPPER_INIT > 15) begin : g_param_check
    $error("coin_change_dispenser: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_DRIVE,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  state_t        state, state_nx;
  // Index 0..4 = five, ten, twenty, fifty, hundred; matches the one-hot coin bit positions.
  logic [3:0]    cnt    [5];
  logic [3:0]    cnt_nx [5];
  logic [4:0]    coin_q, coin_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [GW-1:0] gap_cnt, gap_nx;
  logic [4:0]    pick;
  logic          any_left;
  logic          load_any;
  logic [11:0]   value;

`ifdef HOPPER_COUNT_EN
  localparam logic [3:0] HOP_INIT = 4'(HOPPER_INIT);
  logic [3:0] stock    [5];
  logic [3:0] stock_nx [5];
  logic [4:0] empty_q, empty_nx;
  logic [3:0] pick_stock;
`endif

  // Highest nonzero denomination wins because later (larger) indices overwrite.
  always_comb begin
    pick     = '0;
    any_left = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (cnt[i] != '0) begin
        pick     = '0;
        pick[i]  = 1'b1;
        any_left = 1'b1;
      end
    end
  end

`ifdef HOPPER_COUNT_EN
  always_comb begin
    pick_stock = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (pick[i]) pick_stock = stock[i];
    end
  end
`endif

  assign load_any = |{bus.five, bus.ten, bus.twenty, bus.fifty, bus.hundred};

  always_comb begin
    value = 12'(cnt[0]) * 12'd5  + 12'(cnt[1]) * 12'd10 + 12'(cnt[2]) * 12'd20
          + 12'(cnt[3]) * 12'd50 + 12'(cnt[4]) * 12'd100;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    coin_nx  = coin_q;
    timer_nx = timer;
    gap_nx   = gap_cnt;
`ifdef HOPPER_COUNT_EN
    stock_nx = stock;
    empty_nx = empty_q;
`endif

    case (state)
      S_IDLE: begin
        coin_nx = '0;
        if (bus.load) begin
          cnt_nx[0] = bus.five;
          cnt_nx[1] = bus.ten;
          cnt_nx[2] = bus.twenty;
          cnt_nx[3] = bus.fifty;
          cnt_nx[4] = bus.hundred;
          state_nx  = load_any ? S_SELECT : S_DONE;
        end
      end

      S_SELECT: begin
        if (!any_left) begin
          state_nx = S_DONE;
`ifdef HOPPER_COUNT_EN
        end else if (pick_stock == '0) begin
          empty_nx = pick;
          state_nx = S_FAULT;
`endif
        end else begin
          coin_nx  = pick;
          timer_nx = '0;
          state_nx = S_DRIVE;
        end
      end

      S_DRIVE: begin
        if (bus.coin_ack) begin
          for (int unsigned i = 0; i < 5; i++) begin
            if (coin_q[i]) begin
              cnt_nx[i] = cnt[i] - 4'd1;
`ifdef HOPPER_COUNT_EN
              stock_nx[i] = stock[i] - 4'd1;
`endif
            end
          end
          coin_nx  = '0;
          gap_nx   = '0;
          state_nx = S_GAP;
        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
          coin_nx  = '0;
          state_nx = S_FAULT;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end

      S_GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          state_nx = any_left ? S_SELECT : S_DONE;
        end else begin
          gap_nx = gap_cnt + GW'(1);
        end
      end

      S_DONE:  state_nx = S_IDLE;
      S_FAULT: state_nx = S_FAULT;
      default: state_nx = S_IDLE;
    endcase

    // Abort overrides every branch above, including an ack in the same cycle.
    if (bus.abort && state != S_IDLE) begin
      state_nx = S_IDLE;
      coin_nx  = '0;
      for (int unsigned i = 0; i < 5; i++) cnt_nx[i] = '0;
`ifdef HOPPER_COUNT_EN
      stock_nx = stock;
      empty_nx = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      coin_q  <= '0;
      timer   <= '0;
      gap_cnt <= '0;
      for (int unsigned i = 0; i < 5; i++) cnt[i] <= '0;
`ifdef HOPPER_COUNT_EN
      for (int unsigned i = 0; i < 5; i++) stock[i] <= HOP_INIT;
      empty_q <= '0;
`endif
    end else begin
      state   <= state_nx;
      coin_q  <= coin_nx;
      timer   <= timer_nx;
      gap_cnt <= gap_nx;
      for (int unsigned i = 0; i < 5; i++) cnt[i] <= cnt_nx[i];
`ifdef HOPPER_COUNT_EN
      for (int unsigned i = 0; i < 5; i++) stock[i] <= stock_nx[i];
      empty_q <= empty_nx;
`endif
    end
  end

  assign bus.coin_valid = (state == S_DRIVE);
  assign bus.coin_out   = (state == S_DRIVE) ? coin_q : '0;
  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = (state == S_DONE);
  assign bus.fault      = (state == S_FAULT);
  assign bus.value_left = value;
`ifdef HOPPER_COUNT_EN
  assign bus.hopper_empty = empty_q;
`else
  assign bus.hopper_empty = '0;
`endif

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Self-checking bench for coin_change_dispenser: table-driven jobs with a coin scoreboard
// plus hand-written timeout, abort, reset and hopper sequences.
module tb_coin_change_dispenser;
  localparam int unsigned GAP    = 4;
  localparam int unsigned TMO    = 12;
  localparam int unsigned HINIT  = 2;
  localparam int unsigned BUDGET = 2000;

  typedef struct {
    logic [3:0]  five;
    logic [3:0]  ten;
    logic [3:0]  twenty;
    logic [3:0]  fifty;
    logic [3:0]  hundred;
    int unsigned ack_delay;
    bit          noise;
    int unsigned exp_value;
    int unsigned exp_ncoins;
  } job_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  coin_change_dispenser_if bus ();

  coin_change_dispenser #(
    .GAP_CYCLES (GAP),
    .ACK_TIMEOUT(TMO),
    .HOPPER_INIT(HINIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [4:0]  exp_q[$];
  int unsigned model_val;
  job_t        jobs[7];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned coin_val(input logic [4:0] c);
    case (c)
      5'b00001: return 5;
      5'b00010: return 10;
      5'b00100: return 20;
      5'b01000: return 50;
      5'b10000: return 100;
      default:  return 0;
    endcase
  endfunction

  task automatic drive_idle();
    bus.load = 1'b0; bus.abort = 1'b0; bus.coin_ack = 1'b0;
    bus.five = '0; bus.ten = '0; bus.twenty = '0; bus.fifty = '0; bus.hundred = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic start_load(input logic [3:0] c5, input logic [3:0] c10, input logic [3:0] c20,
                            input logic [3:0] c50, input logic [3:0] c100);
    bus.load = 1'b1;
    bus.five = c5; bus.ten = c10; bus.twenty = c20; bus.fifty = c50; bus.hundred = c100;
  endtask

  task automatic wait_valid(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_idle();
      if (bus.coin_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  task automatic run_job(input job_t j);
    int unsigned rel = 0, vcnt = 0, low_cnt = 0, ncoins = 0;
    bit seen = 1'b0, finished = 1'b0;
    logic [4:0] code;
    check("idle_before_load", bus.busy, 0);
    exp_q.delete();
    for (int k = 0; k < int'(j.hundred); k++) exp_q.push_back(5'b10000);
    for (int k = 0; k < int'(j.fifty);   k++) exp_q.push_back(5'b01000);
    for (int k = 0; k < int'(j.twenty);  k++) exp_q.push_back(5'b00100);
    for (int k = 0; k < int'(j.ten);     k++) exp_q.push_back(5'b00010);
    for (int k = 0; k < int'(j.five);    k++) exp_q.push_back(5'b00001);
    model_val = 5 * j.five + 10 * j.ten + 20 * j.twenty + 50 * j.fifty + 100 * j.hundred;
    start_load(j.five, j.ten, j.twenty, j.fifty, j.hundred);
    while (!finished && rel < BUDGET) begin
      @(negedge clk);
      rel++;
      drive_idle();
      if (rel == 1) check("value_after_load", bus.value_left, j.exp_value);
      if (bus.coin_valid) begin
        if (vcnt == 0) begin
          if (!seen) check("first_coin_latency", rel, 2);
          else       check("gap_low_cycles", low_cnt, GAP + 1);
          check("value_at_coin", bus.value_left, model_val);
          check("coin_expected", exp_q.size() != 0, 1);
        end
        vcnt++;
        if (vcnt == j.ack_delay && exp_q.size() != 0) begin
          bus.coin_ack = 1'b1;
          code = exp_q.pop_front();
          check("coin_out", bus.coin_out, code);
          model_val -= coin_val(code);
          ncoins++;
          seen    = 1'b1;
          low_cnt = 0;
        end
      end else begin
        check("coin_out_when_invalid", bus.coin_out, 0);
        vcnt = 0;
        low_cnt++;
        if (j.noise && seen && !bus.done) begin
          bus.coin_ack = 1'b1;
          bus.load     = 1'b1;
          bus.hundred  = 4'd5;
        end
      end
      if (bus.done) begin
        check("done_value_left", bus.value_left, 0);
        check("done_queue_empty", exp_q.size(), 0);
        check("done_busy", bus.busy, 1);
        check("coins_dispensed", ncoins, j.exp_ncoins);
        if (j.exp_ncoins == 0) check("zero_job_done_latency", rel, 1);
        finished = 1'b1;
      end
    end
    check("job_finished", finished, 1);
    @(negedge clk);
    drive_idle();
    check("post_done_busy", bus.busy, 0);
    check("single_done_pulse", bus.done, 0);
  endtask

  initial begin
    int unsigned vcyc, ncoins;
    logic [3:0]  mx;
    reset = 1'b0;
    drive_idle();
    jobs[0] = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 1,   1'b0, 125,  3};
    jobs[1] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1,   1'b0, 0,    0};
    jobs[2] = '{4'd2, 4'd1, 4'd0, 4'd1, 4'd0, 3,   1'b0, 70,   4};
    jobs[3] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, TMO, 1'b0, 100,  1};
    jobs[4] = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 1, 1'b0, 2775, 75};
    jobs[5] = '{4'd0, 4'd3, 4'd0, 4'd2, 4'd0, 2,   1'b0, 130,  5};
    jobs[6] = '{4'd0, 4'd2, 4'd0, 4'd0, 4'd0, 1,   1'b1, 20,   2};

    repeat (2) @(negedge clk);
    check("reset_coin_valid", bus.coin_valid, 0);
    check("reset_coin_out", bus.coin_out, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_fault", bus.fault, 0);
    check("reset_value_left", bus.value_left, 0);
    check("reset_hopper_empty", bus.hopper_empty, 0);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      mx = jobs[i].five;
      if (jobs[i].ten > mx)     mx = jobs[i].ten;
      if (jobs[i].twenty > mx)  mx = jobs[i].twenty;
      if (jobs[i].fifty > mx)   mx = jobs[i].fifty;
      if (jobs[i].hundred > mx) mx = jobs[i].hundred;
`ifdef HOPPER_COUNT_EN
      if (int'(mx) > int'(HINIT)) continue;
`endif
      do_reset();
      run_job(jobs[i]);
    end

    // Ack timeout, fault is sticky and ignores ack, abort clears it.
    do_reset();
    start_load(4'd0, 4'd0, 4'd0, 4'd0, 4'd1);
    vcyc = 0;
    for (int i = 0; i < int'(3 * TMO); i++) begin
      @(negedge clk);
      drive_idle();
      if (bus.coin_valid) vcyc++;
      if (bus.fault) break;
    end
    check("timeout_valid_cycles", vcyc, TMO);
    check("timeout_fault", bus.fault, 1);
    check("fault_coin_valid", bus.coin_valid, 0);
    check("fault_value_held", bus.value_left, 100);
    check("fault_busy", bus.busy, 1);
    check("fault_hopper_empty", bus.hopper_empty, 0);
    bus.coin_ack = 1'b1;
    repeat (3) @(negedge clk);
    bus.coin_ack = 1'b0;
    check("fault_sticky", bus.fault, 1);
    check("fault_ack_ignored", bus.value_left, 100);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_fault_clear", bus.fault, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_value_left", bus.value_left, 0);
    check("abort_no_done", bus.done, 0);

    // Abort together with ack: abort wins, job dropped with no done.
    do_reset();
    start_load(4'd0, 4'd0, 4'd0, 4'd2, 4'd0);
    wait_valid("abort_ack_valid_seen");
    bus.coin_ack = 1'b1;
    bus.abort    = 1'b1;
    @(negedge clk);
    drive_idle();
    check("abort_ack_busy", bus.busy, 0);
    check("abort_ack_coin_valid", bus.coin_valid, 0);
    check("abort_ack_value_left", bus.value_left, 0);
    check("abort_ack_no_done", bus.done, 0);
    @(negedge clk);
    check("abort_ack_no_late_done", bus.done, 0);
    run_job('{4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 1, 1'b0, 50, 1});

    // Reset asserted while a coin is presented.
    do_reset();
    start_load(4'd0, 4'd0, 4'd3, 4'd0, 4'd0);
    wait_valid("reset_drive_valid_seen");
    reset = 1'b0;
    @(negedge clk);
    check("rst_drive_coin_valid", bus.coin_valid, 0);
    check("rst_drive_busy", bus.busy, 0);
    check("rst_drive_value_left", bus.value_left, 0);
    check("rst_drive_no_done", bus.done, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_drive_no_late_done", bus.done, 0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("idle_abort_busy", bus.busy, 0);
    check("idle_abort_done", bus.done, 0);
    run_job('{4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 1, 1'b0, 20, 1});

`ifdef HOPPER_COUNT_EN
    // Hopper of HINIT=2 tens runs dry on the third coin; stock survives abort.
    do_reset();
    start_load(4'd0, 4'd3, 4'd0, 4'd0, 4'd0);
    ncoins = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      drive_idle();
      if (bus.coin_valid) begin
        bus.coin_ack = 1'b1;
        ncoins++;
      end
      if (bus.fault) break;
    end
    check("hopper_coins_before_fault", ncoins, 2);
    check("hopper_fault", bus.fault, 1);
    check("hopper_empty_code", bus.hopper_empty, 5'b00010);
    check("hopper_value_left", bus.value_left, 10);
    check("hopper_coin_valid", bus.coin_valid, 0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("hopper_abort_clear", bus.hopper_empty, 0);
    check("hopper_abort_fault", bus.fault, 0);
    start_load(4'd0, 4'd1, 4'd0, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    drive_idle();
    check("hopper_stock_kept_fault", bus.fault, 1);
    check("hopper_stock_kept_code", bus.hopper_empty, 5'b00010);
`else
    ncoins = 0;
    check("hopper_tied_zero", bus.hopper_empty + ncoins, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
